// File: rtl/control_unit_p.sv
// -----------------------------------------------------------------------------
// control_unit_p
//
// Purpose:
//   Moore microcoded control unit for the phase-1 ARM data path. A small
//   fetch/decode sequencer walks through the instruction fetch (S1..S4),
//   decodes the fetched instruction (S5) and then runs one of the execute
//   states: data processing with write-back (S10/S11), compare/test without
//   write-back (S14/S15) or the load/store-multiple loop (S20). Each state
//   emits a 34-bit control word on CU_OUT.
//
// Parameters:
//   STATE_W     state register width (encodings 0..2**STATE_W-1)
//
// Ports:
//   CLK         in   1   clock, all state changes on the rising edge
//   RST         in   1   synchronous active-high reset (state -> S0)
//   IR          in   32  instruction register contents
//   MOC         in   1   memory operation complete
//   COND        in   1   1 = IR[31:28] condition satisfied
//   LSM_DETECT  in   1   1 = LSM register list not empty
//   LSM_END     in   1   1 = last LSM transfer
//   CU_OUT      out  34  control word
//   STATE       out  STATE_W current state (debug)
//
// CU_OUT field map (MSB first):
//   33 FRLd | 32 RFLd | 31 IRLd | 30 MARLd | 29 MDRLd | 28 R/W | 27 MOV
//   26:25 MA | 24:22 MB | 21:19 MC | 18:17 MD | 16 ME | 15:11 OP
//   10 SLS_EN | 9:7 MS | 6 LSM_EN | 5:3 LSM_IN | 2:1 MH | 0 MF
//
// Configuration macro:
//   MOC_WAIT_EN  defined   : S3 holds until MOC=1 (variable-latency memory).
//                undefined : MOC is ignored and S3 always advances to S4
//                            (single-cycle memory).
// -----------------------------------------------------------------------------
module control_unit_p #(
  parameter int STATE_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        IR,
  input  logic               MOC,
  input  logic               COND,
  input  logic               LSM_DETECT,
  input  logic               LSM_END,
  output logic [33:0]        CU_OUT,
  output logic [STATE_W-1:0] STATE
);

  // ---------------------------------------------------------------------------
  // State encodings
  // ---------------------------------------------------------------------------
  localparam logic [STATE_W-1:0] S0  = STATE_W'(0);   // idle
  localparam logic [STATE_W-1:0] S1  = STATE_W'(1);   // MAR <- PC
  localparam logic [STATE_W-1:0] S2  = STATE_W'(2);   // PC <- PC + 4, start read
  localparam logic [STATE_W-1:0] S3  = STATE_W'(3);   // MDR <- memory
  localparam logic [STATE_W-1:0] S4  = STATE_W'(4);   // IR <- MDR
  localparam logic [STATE_W-1:0] S5  = STATE_W'(5);   // decode
  localparam logic [STATE_W-1:0] S10 = STATE_W'(10);  // DP register, write-back
  localparam logic [STATE_W-1:0] S11 = STATE_W'(11);  // DP immediate, write-back
  localparam logic [STATE_W-1:0] S14 = STATE_W'(14);  // DP register, test only
  localparam logic [STATE_W-1:0] S15 = STATE_W'(15);  // DP immediate, test only
  localparam logic [STATE_W-1:0] S20 = STATE_W'(20);  // LSM transfer loop

  // ---------------------------------------------------------------------------
  // Mux select / ALU codes
  // ---------------------------------------------------------------------------
  localparam logic [1:0] MA_RN    = 2'b00;
  localparam logic [1:0] MA_R15   = 2'b01;
  localparam logic [2:0] MB_PB    = 3'b000;
  localparam logic [2:0] MB_SHIFT = 3'b001;
  localparam logic [2:0] MB_FOUR  = 3'b010;
  localparam logic [2:0] MC_R15   = 3'b001;
  localparam logic [2:0] MC_RD    = 3'b011;
  localparam logic [1:0] MD_MEM   = 2'b01;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_PASSA = 5'b10000;

  // Instruction class field IR[27:25]
  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LSM    = 3'b100;

  // Data-processing opcodes 10xx (TST/TEQ/CMP/CMN) only update flags
  localparam logic [1:0] OPC_TEST   = 2'b10;

  // ---------------------------------------------------------------------------
  // Control word layout; packing order matches the CU_OUT bit map exactly.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       frld;    // 33
    logic       rfld;    // 32
    logic       irld;    // 31
    logic       marld;   // 30
    logic       mdrld;   // 29
    logic       rw;      // 28
    logic       mov;     // 27
    logic [1:0] ma;      // 26:25
    logic [2:0] mb;      // 24:22
    logic [2:0] mc;      // 21:19
    logic [1:0] md;      // 18:17
    logic       me;      // 16
    logic [4:0] op;      // 15:11
    logic       sls_en;  // 10
    logic [2:0] ms;      // 9:7
    logic       lsm_en;  // 6
    logic [2:0] lsm_in;  // 5:3
    logic [1:0] mh;      // 2:1
    logic       mf;      // 0
  } ctrl_word_t;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_word_t         cw;

  // Decoded instruction fields used by the decode and execute states
  logic [2:0] ir_class;
  logic       ir_bit4;
  logic [1:0] ir_opc_hi;
  logic [3:0] ir_opcode;
  logic       ir_sbit;
  logic [2:0] ir_lsm_mode;
  logic       mem_done;

  assign ir_class    = IR[27:25];
  assign ir_bit4     = IR[4];
  assign ir_opc_hi   = IR[24:23];
  assign ir_opcode   = IR[24:21];
  assign ir_sbit     = IR[20];
  assign ir_lsm_mode = IR[24:22];

`ifdef MOC_WAIT_EN
  // Variable-latency memory: hold the read until the memory acknowledges.
  assign mem_done = MOC;
  logic unused_ir;
  assign unused_ir = ^{IR[31:28], IR[19:5], IR[3:0]};
`else
  // Single-cycle memory: the data is always ready one cycle after the strobe.
  assign mem_done = 1'b1;
  logic unused_ir;
  assign unused_ir = ^{IR[31:28], IR[19:5], IR[3:0], MOC};
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = S1;
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = mem_done ? S4 : S3;
      S4: state_d = S5;
      S5: begin
        if (!COND) begin
          // Condition failed: the instruction becomes a no-op, fetch the next.
          state_d = S1;
        end else if (ir_class == CLS_DP_REG && !ir_bit4) begin
          // IR[4]=1 in this class is a register-specified shift or a
          // multiply/extension encoding, neither of which is supported yet.
          state_d = (ir_opc_hi == OPC_TEST) ? S14 : S10;
        end else if (ir_class == CLS_DP_IMM) begin
          state_d = (ir_opc_hi == OPC_TEST) ? S15 : S11;
        end else if (ir_class == CLS_LSM) begin
          state_d = S20;
        end else begin
          state_d = S1;
        end
      end
      S10, S11, S14, S15: state_d = S1;
      S20: begin
        if (!LSM_DETECT || LSM_END) begin
          state_d = S1;
        end else begin
          state_d = S20;
        end
      end
      default: state_d = S0;  // unused encodings recover through idle
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (Moore: state register plus the registered IR fields)
  // ---------------------------------------------------------------------------
  always_comb begin
    cw = '0;
    case (state_q)
      S1: begin
        cw.ma    = MA_R15;
        cw.op    = OP_PASSA;
        cw.marld = 1'b1;
      end
      S2: begin
        // PC + 4 written back into R15 while the read strobe starts.
        cw.ma   = MA_R15;
        cw.mb   = MB_FOUR;
        cw.op   = OP_ADD;
        cw.mc   = MC_R15;
        cw.rfld = 1'b1;
        cw.mov  = 1'b1;
        cw.rw   = 1'b1;
      end
      S3: begin
        cw.mov   = 1'b1;
        cw.rw    = 1'b1;
        cw.mdrld = 1'b1;
        cw.md    = MD_MEM;
      end
      S4: begin
        cw.irld = 1'b1;
        cw.md   = MD_MEM;
      end
      S10, S11: begin
        // For S11 the shifter already presents the rotated immediate on B.
        cw.ma   = MA_RN;
        cw.mb   = MB_SHIFT;
        cw.mc   = MC_RD;
        cw.rfld = 1'b1;
        cw.frld = ir_sbit;
        cw.op   = {1'b0, ir_opcode};
      end
      S14, S15: begin
        // Test/compare: flags always update, destination never written.
        cw.ma   = MA_RN;
        cw.mb   = MB_SHIFT;
        cw.rfld = 1'b0;
        cw.frld = 1'b1;
        cw.op   = {1'b0, ir_opcode};
      end
      S20: begin
        cw.lsm_en = 1'b1;
        cw.lsm_in = ir_lsm_mode;
      end
      default: cw = '0;
    endcase
  end

  // MB_PB is the idle select for the B mux; referenced so the code table
  // stays complete alongside the other selects.
  logic unused_mb_pb;
  assign unused_mb_pb = ^MB_PB;

  assign CU_OUT = cw;
  assign STATE  = state_q;

endmodule

// File: tb/tb_control_unit_p.sv
// -----------------------------------------------------------------------------
// tb_control_unit_p
//
// Self-checking bench for control_unit_p: directed walk-through of fetch,
// decode and execute, then randomized inputs compared every cycle against a
// behavioural model of the state sequence and the control word it implies.
// -----------------------------------------------------------------------------
module tb_control_unit_p;

`ifdef MOC_WAIT_EN
  localparam bit MOC_WAIT = 1'b1;
`else
  localparam bit MOC_WAIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0;
  logic        moc = 1'b0;
  logic        cond = 1'b0;
  logic        lsm_detect = 1'b0;
  logic        lsm_end = 1'b0;
  logic [33:0] cu_out;
  logic [5:0]  state;

  int checks = 0;
  int errors = 0;
  int model_state = 0;

  control_unit_p #(.STATE_W(6)) dut (
    .CLK(clk), .RST(rst), .IR(ir), .MOC(moc), .COND(cond),
    .LSM_DETECT(lsm_detect), .LSM_END(lsm_end), .CU_OUT(cu_out), .STATE(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Next state from the sequencing rules.
  function automatic int ref_next(int s, logic r, logic [31:0] i, logic m,
                                  logic c, logic d, logic e);
    if (r) return 0;
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return (m || !MOC_WAIT) ? 4 : 3;
      4: return 5;
      5: begin
        if (!c) return 1;
        if (i[27:25] == 3'b000 && !i[4]) return (i[24:23] == 2'b10) ? 14 : 10;
        if (i[27:25] == 3'b001) return (i[24:23] == 2'b10) ? 15 : 11;
        if (i[27:25] == 3'b100) return 20;
        return 1;
      end
      10, 11, 14, 15: return 1;
      20: return (!d || e) ? 1 : 20;
      default: return 0;
    endcase
  endfunction

  // Place a field value at a bit position of the control word.
  function automatic logic [63:0] fld(input logic [7:0] v, input int pos);
    return 64'(v) << pos;
  endfunction

  // Control word expected in a state, built from named field positions.
  function automatic logic [33:0] ref_cw(int s, logic [31:0] i);
    logic [63:0] w;
    logic [7:0]  opc;
    logic [7:0]  lsm;
    logic [7:0]  sb;
    opc = 8'(i[24:21]);
    lsm = 8'(i[24:22]);
    sb  = 8'(i[20]);
    w   = '0;
    case (s)
      1:  w = fld(1, 30) | fld(1, 25) | fld(8'h10, 11);
      2:  w = fld(1, 25) | fld(2, 22) | fld(4, 11) | fld(1, 19)
            | fld(1, 32) | fld(1, 27) | fld(1, 28);
      3:  w = fld(1, 27) | fld(1, 28) | fld(1, 29) | fld(1, 17);
      4:  w = fld(1, 31) | fld(1, 17);
      10, 11: w = fld(1, 22) | fld(3, 19) | fld(1, 32) | fld(sb, 33) | fld(opc, 11);
      14, 15: w = fld(1, 22) | fld(1, 33) | fld(opc, 11);
      20: w = fld(1, 6) | fld(lsm, 3);
      default: w = '0;
    endcase
    return w[33:0];
  endfunction

  // One clock: advance the model with the inputs presented, compare outputs.
  task automatic step(input string tag);
    int nxt;
    nxt = ref_next(model_state, rst, ir, moc, cond, lsm_detect, lsm_end);
    @(posedge clk);
    #1;
    model_state = nxt;
    check({tag, ".state"}, 34'(state), 34'(model_state));
    check({tag, ".cu_out"}, cu_out, ref_cw(model_state, ir));
    $display("%s st=%0d cu=%h", tag, state, cu_out);
  endtask

  // Reset, then fetch up to S5 with the given instruction/condition.
  task automatic boot(input logic [31:0] i, input logic c);
    ir = i; cond = c; moc = 1'b1; lsm_detect = 1'b0; lsm_end = 1'b0;
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
    repeat (5) step("fetch");
  endtask

  initial begin
    // Reset state
    rst = 1'b1; moc = 1'b1;
    step("reset");
    check("reset.state0", 34'(state), 34'd0);
    check("reset.cu0", cu_out, 34'd0);

    // Fetch sequence
    rst = 1'b0; ir = 32'hE09A102C; cond = 1'b1;
    step("s1");
    check("s1.marld", 34'(cu_out[30]), 34'd1);
    check("s1.ma", 34'(cu_out[26:25]), 34'd1);
    step("s2");
    check("s2.rfld", 34'(cu_out[32]), 34'd1);
    check("s2.mb", 34'(cu_out[24:22]), 34'd2);
    step("s3");
    step("s4");
    step("s5");
    check("s5.state", 34'(state), 34'd5);

    // Data processing register, S-bit set
    step("dp_reg");
    check("s10.state", 34'(state), 34'd10);
    check("s10.rfld", 34'(cu_out[32]), 34'd1);
    check("s10.frld", 34'(cu_out[33]), 34'd1);
    check("s10.mb", 34'(cu_out[24:22]), 34'd1);
    check("s10.mc", 34'(cu_out[21:19]), 34'd3);
    check("s10.op", 34'(cu_out[15:11]), 34'h04);
    step("back");
    check("s10.next", 34'(state), 34'd1);

    // Data processing immediate
    boot(32'hF29A102C, 1'b1);
    step("dp_imm");
    check("s11.state", 34'(state), 34'd11);

    // Test/compare: flags only
    boot(32'hF13A102C, 1'b1);
    step("dp_tst");
    check("s14.state", 34'(state), 34'd14);
    check("s14.rfld", 34'(cu_out[32]), 34'd0);
    check("s14.frld", 34'(cu_out[33]), 34'd1);

    // Condition fails
    boot(32'hE09A102C, 1'b0);
    step("nocond");
    check("nocond.state", 34'(state), 34'd1);
    check("nocond.ld", 34'(cu_out[33:32]), 34'd0);

    // LSM loop: stays while list not empty and not last
    boot(32'hE8BD0003, 1'b1);
    lsm_detect = 1'b1; lsm_end = 1'b0;
    step("lsm");
    step("lsm");
    check("lsm.stay", 34'(state), 34'd20);
    lsm_end = 1'b1;
    step("lsm_end");
    check("lsm.exit", 34'(state), 34'd1);

    // Memory wait in S3
    rst = 1'b1; step("reset");
    rst = 1'b0; moc = 1'b0;
    repeat (3) step("fetch");
`ifdef MOC_WAIT_EN
    repeat (3) begin
      step("mocwait");
      check("mocwait.hold", 34'(state), 34'd3);
    end
    rst = 1'b1;
    step("mocwait_rst");
    check("mocwait.rst", 34'(state), 34'd0);
`else
    step("nomocwait");
    check("nomoc.adv", 34'(state), 34'd4);
`endif

    // Randomized run
    rst = 1'b1; step("reset");
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(63) == 0);
      ir  = $urandom;
      case ($urandom_range(3))
        0: ir[27:25] = 3'b000;
        1: ir[27:25] = 3'b001;
        2: ir[27:25] = 3'b100;
        default: ;
      endcase
      moc        = 1'($urandom_range(1));
      cond       = ($urandom_range(3) != 0);
      lsm_detect = ($urandom_range(7) != 0);
      lsm_end    = ($urandom_range(3) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
